// File: rtl/cmd_register_sequencer_if.sv
// rtl/cmd_register_sequencer_if.sv - command/accessory bus bundle for cmd_register_sequencer
//
// Groups the serial command inputs, the decoded command outputs and the
// per-channel accessory handshake into one bundle.
//   master : drives shift_en, ser_in, word_sync, exec, io_ready; observes the rest
//   slave  : the sequencer side (receives commands, drives decoders and io_*)
interface cmd_register_sequencer_if #(
  parameter int D_W  = 5,
  parameter int S_W  = 5,
  parameter int CH_W = 2,
  parameter int N_IO = 4
);
  // serial command stream
  logic                  shift_en;
  logic                  ser_in;
  logic                  word_sync;
  logic                  exec;
  // active command and its decoders
  logic                  sd_bit;
  logic [D_W-1:0]        dest;
  logic [S_W-1:0]        src;
  logic [CH_W-1:0]       char;
  logic [(2**D_W)-1:0]   dest_onehot;
  logic [(2**S_W)-1:0]   src_onehot;
  logic                  cmd_valid;
  logic                  cs_out;
  logic                  ds_out;
  // accessory transfer handshake
  logic [N_IO-1:0]       io_ready;
  logic [N_IO-1:0]       io_start;
  logic [N_IO-1:0]       io_stop;
  logic [N_IO-1:0]       io_shift;
  logic                  io_busy;
  logic                  io_timeout;

  modport master (
    output shift_en, ser_in, word_sync, exec, io_ready,
    input  sd_bit, dest, src, char, dest_onehot, src_onehot, cmd_valid,
           cs_out, ds_out, io_start, io_stop, io_shift, io_busy, io_timeout
  );

  modport slave (
    input  shift_en, ser_in, word_sync, exec, io_ready,
    output sd_bit, dest, src, char, dest_onehot, src_onehot, cmd_valid,
           cs_out, ds_out, io_start, io_stop, io_shift, io_busy, io_timeout
  );
endinterface

// File: rtl/cmd_register_sequencer.sv
// rtl/cmd_register_sequencer.sv - shadow/active command register with accessory transfer sequencer
//
// A serial command word (LSB->MSB: sd, dest, src, char) is shifted into a
// shadow register and committed atomically to the active register on the
// last bit, so the decoders stay stable while the next word streams in.
// A special-destination command qualified by exec starts a per-channel
// accessory transfer: start pulse, XFER_BITS gated shifts, stop pulse, with
// a stall timeout.
// Ports:
//   CLOCK : system clock, all state on its rising edge
//   rst   : synchronous reset, active low
//   bus   : slave side of cmd_register_sequencer_if (command stream,
//           decoded fields, accessory io_* handshake)
module cmd_register_sequencer #(
  parameter int D_W       = 5,
  parameter int S_W       = 5,
  parameter int CH_W      = 2,
  parameter int N_IO      = 4,
  parameter int XFER_BITS = 29,
  parameter int TMO_W     = 12,
  parameter int SPECIAL_D = 31
) (
  input  logic                  CLOCK,
  input  logic                  rst,
  cmd_register_sequencer_if.slave bus
);

  localparam int W        = 1 + D_W + S_W + CH_W;
  localparam int CNT_W    = $clog2(W);
  localparam int CH_IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int LEN_W    = $clog2(XFER_BITS + 1);
  localparam int DEC_D_W  = 2 ** D_W;
  localparam int DEC_S_W  = 2 ** S_W;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
  localparam logic [LEN_W-1:0] XFER_LEN = LEN_W'(XFER_BITS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [D_W-1:0]   SPECIAL  = D_W'(SPECIAL_D);
  // The stall that takes tmo from all-ones-minus-one to all-ones is the timeout.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  // ---------------------------------------------------------------------------
  // Shadow / active command register
  // ---------------------------------------------------------------------------
  logic [W-1:0]     shadow;
  logic [W-1:0]     active;
  logic [CNT_W-1:0] count;
  logic             cmd_valid_q;
  logic [W-1:0]     shadow_shifted;

  assign shadow_shifted = {bus.ser_in, shadow[W-1:1]};

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      shadow      <= '0;
      active      <= '0;
      count       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (bus.shift_en) begin
        shadow <= shadow_shifted;
      end
      // word_sync realigns the word boundary; it never commits, even on the
      // cycle that would otherwise have been the last bit.
      if (bus.word_sync) begin
        count <= '0;
      end else if (bus.shift_en) begin
        if (count == LAST_BIT) begin
          count       <= '0;
          active      <= shadow_shifted;
          cmd_valid_q <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active fields and decoders
  // ---------------------------------------------------------------------------
  assign bus.sd_bit      = active[0];
  assign bus.dest        = active[D_W:1];
  assign bus.src         = active[D_W+S_W:D_W+1];
  assign bus.char        = active[W-1:W-CH_W];
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.dest_onehot = DEC_D_W'(1) << bus.dest;
  assign bus.src_onehot  = DEC_S_W'(1) << bus.src;
  assign bus.cs_out      = bus.char[CH_W-1] & (bus.dest != '1) & (bus.src != '1);
  assign bus.ds_out      = bus.exec & (bus.dest == SPECIAL);

  // ---------------------------------------------------------------------------
  // Accessory transfer sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_XFER,
    ST_STOP
  } state_t;

  state_t              state, state_nxt;
  logic [CH_IDX_W-1:0] ch, ch_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [TMO_W-1:0]    tmo, tmo_nxt;
  logic                timeout_q, timeout_nxt;
  logic [CH_IDX_W-1:0] src_ch;
  logic [N_IO-1:0]     ch_mask;

  assign src_ch  = (N_IO > 1) ? bus.src[CH_IDX_W-1:0] : '0;
  assign ch_mask = N_IO'(1) << ch;

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      len       <= '0;
      tmo       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      len       <= len_nxt;
      tmo       <= tmo_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    len_nxt      = len;
    tmo_nxt      = tmo;
    timeout_nxt  = timeout_q;
    bus.io_start = '0;
    bus.io_shift = '0;
    bus.io_stop  = '0;
    case (state)
      ST_IDLE: begin
        // Only an idle sequencer accepts a DS start; exec while busy is dropped.
        if (bus.ds_out) begin
          ch_nxt      = src_ch;
          len_nxt     = XFER_LEN;
          tmo_nxt     = '0;
          timeout_nxt = 1'b0;
          state_nxt   = ST_START;
        end
      end
      ST_START: begin
        bus.io_start = ch_mask;
        state_nxt    = ST_XFER;
      end
      ST_XFER: begin
        if (bus.io_ready[ch]) begin
          bus.io_shift = ch_mask;
          len_nxt      = len - 1'b1;
          tmo_nxt      = '0;
          if (len == LEN_ONE) begin
            state_nxt = ST_STOP;
          end
        end else begin
          tmo_nxt = tmo + 1'b1;
          if (tmo == TMO_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        bus.io_stop = ch_mask;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.io_busy    = (state != ST_IDLE);
  assign bus.io_timeout = timeout_q;

endmodule

// File: tb/tb_cmd_register_sequencer.sv
// tb/tb_cmd_register_sequencer.sv - scoreboard bench for cmd_register_sequencer
module tb_cmd_register_sequencer;

  localparam int D_W       = 5;
  localparam int S_W       = 5;
  localparam int CH_W      = 2;
  localparam int N_IO      = 4;
  localparam int XFER_BITS = 29;
  localparam int TMO_W     = 4;
  localparam int SPECIAL_D = 31;
  localparam int W         = 1 + D_W + S_W + CH_W;
  localparam int STALL_MAX = (1 << TMO_W) - 1;

  localparam logic [1:0] K_START = 2'd1;
  localparam logic [1:0] K_SHIFT = 2'd2;
  localparam logic [1:0] K_STOP  = 2'd3;

  typedef struct packed {
    logic [1:0]      kind;
    logic [N_IO-1:0] vec;
    logic            tmo;
  } io_ev_t;

  logic clk;
  logic rst;
  bit   mon_en;
  int   checks;
  int   errors;

  logic [W-1:0] exp_cmd[$];
  io_ev_t       exp_io[$];
  int           exp_busy[$];

  cmd_register_sequencer_if #(.D_W(D_W), .S_W(S_W), .CH_W(CH_W), .N_IO(N_IO)) bus ();

  cmd_register_sequencer #(
    .D_W(D_W), .S_W(S_W), .CH_W(CH_W), .N_IO(N_IO),
    .XFER_BITS(XFER_BITS), .TMO_W(TMO_W), .SPECIAL_D(SPECIAL_D)
  ) dut (
    .CLOCK(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic io_ev_t mk_ev(input logic [1:0] k, input logic [N_IO-1:0] v, input logic t);
    io_ev_t e;
    e.kind = k;
    e.vec  = v;
    e.tmo  = t;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents an output event
  // ---------------------------------------------------------------------------
  int busy_cnt;

  always @(negedge clk) begin : monitor
    logic [W-1:0]     w;
    logic [D_W-1:0]   ed;
    logic [S_W-1:0]   es;
    logic [CH_W-1:0]  ec;
    io_ev_t           obs;
    io_ev_t           ex;
    logic             s, h, p;
    if (mon_en) begin
      if (bus.cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_valid_unexpected", 64'd1, 64'd0);
        end else begin
          w  = exp_cmd.pop_front();
          ed = w[D_W:1];
          es = w[D_W+S_W:D_W+1];
          ec = w[W-1:W-CH_W];
          check("cmd_sd", bus.sd_bit, w[0]);
          check("cmd_dest", bus.dest, ed);
          check("cmd_src", bus.src, es);
          check("cmd_char", bus.char, ec);
          check("cmd_dest_onehot", bus.dest_onehot, 64'd1 << ed);
          check("cmd_src_onehot", bus.src_onehot, 64'd1 << es);
          check("cmd_cs_out", bus.cs_out, ec[CH_W-1] && (ed != 31) && (es != 31));
        end
      end
      s = |bus.io_start;
      h = |bus.io_shift;
      p = |bus.io_stop;
      if (s || h || p) begin
        obs.kind = (s && !h && !p) ? K_START : (h && !s && !p) ? K_SHIFT : (p && !s && !h) ? K_STOP : 2'd0;
        obs.vec  = bus.io_start | bus.io_shift | bus.io_stop;
        obs.tmo  = bus.io_timeout;
        if (exp_io.size() == 0) begin
          check("io_event_unexpected", 64'(obs), 64'd0);
        end else begin
          ex = exp_io.pop_front();
          check("io_event", 64'(obs), 64'(ex));
        end
      end
      if (bus.io_busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        if (exp_busy.size() == 0) check("busy_unexpected", 64'(busy_cnt), 64'd0);
        else check("busy_len", 64'(busy_cnt), 64'(exp_busy.pop_front()));
        busy_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic sd, input logic [D_W-1:0] d, input logic [S_W-1:0] s,
                          input logic [CH_W-1:0] c, input bit gaps);
    logic [W-1:0] w;
    w = {c, s, d, sd};
    exp_cmd.push_back(w);
    for (int i = 0; i < W; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          bus.shift_en = 1'b0;
          bus.ser_in   = 1'($urandom_range(1));
          tick();
        end
      end
      bus.shift_en = 1'b1;
      bus.ser_in   = w[i];
      tick();
    end
    bus.shift_en = 1'b0;
    check("cmd_valid_timing", bus.cmd_valid, 1'b1);
  endtask

  // Called in the cycle right after a dest=SPECIAL commit. mode: 0 ready held
  // high, 1 ready held low, 2 mostly ready, 3 mostly stalled.
  task automatic run_xfer(input logic [S_W-1:0] s, input int mode);
    bit              rb[1:512];
    int              highs, lows, x;
    bit              tm;
    logic [N_IO-1:0] mask;
    logic [N_IO-1:0] other;
    mask  = N_IO'(1) << s[1:0];
    highs = 0;
    lows  = 0;
    x     = 0;
    tm    = 1'b0;
    for (int k = 1; k <= 512; k++) begin
      case (mode)
        0:       rb[k] = 1'b1;
        1:       rb[k] = 1'b0;
        2:       rb[k] = ($urandom_range(7) != 0);
        default: rb[k] = ($urandom_range(15) == 0);
      endcase
      if (rb[k]) begin
        highs++;
        lows = 0;
      end else begin
        lows++;
      end
      if (highs == XFER_BITS) begin
        x = k;
        break;
      end
      if (lows == STALL_MAX) begin
        x  = k;
        tm = 1'b1;
        break;
      end
    end
    exp_io.push_back(mk_ev(K_START, mask, 1'b0));
    for (int k = 1; k <= x; k++) begin
      if (rb[k]) exp_io.push_back(mk_ev(K_SHIFT, mask, 1'b0));
    end
    exp_io.push_back(mk_ev(K_STOP, mask, tm));
    exp_busy.push_back(x + 2);

    bus.exec = 1'b1;
    tick();
    bus.exec     = 1'b0;
    bus.io_ready = (mode == 0) ? mask : '0;
    check("start_latency", bus.io_start, mask);
    for (int k = 1; k <= x; k++) begin
      tick();
      other        = (mode >= 2) ? N_IO'($urandom) & ~mask : '0;
      bus.io_ready = other | (rb[k] ? mask : '0);
    end
    tick();
    tick();
    bus.io_ready = '0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks        = 0;
    errors        = 0;
    busy_cnt      = 0;
    mon_en        = 1'b0;
    rst           = 1'b0;
    bus.shift_en  = 1'b0;
    bus.ser_in    = 1'b0;
    bus.word_sync = 1'b0;
    bus.exec      = 1'b0;
    bus.io_ready  = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check("rst_dest_onehot", bus.dest_onehot, 64'd1);
    check("rst_src_onehot", bus.src_onehot, 64'd1);
    check("rst_fields", {bus.sd_bit, bus.dest, bus.src, bus.char}, 64'd0);
    check("rst_flags", {bus.cmd_valid, bus.cs_out, bus.ds_out, bus.io_busy, bus.io_timeout}, 64'd0);
    check("rst_io", {bus.io_start, bus.io_stop, bus.io_shift}, 64'd0);
    mon_en = 1'b1;

    // Basic commit: sd=1 dest=3 src=7 char=2
    send_cmd(1'b1, 5'd3, 5'd7, 2'd2, 1'b0);
    check("t1_dest_onehot", bus.dest_onehot, 64'h8);
    check("t1_src_onehot", bus.src_onehot, 64'h80);
    check("t1_cs_out", bus.cs_out, 1'b1);
    tick();
    check("t1_cmd_valid_one_cycle", bus.cmd_valid, 1'b0);

    // word_sync after a partial word discards the partial count
    repeat (6) begin
      bus.shift_en = 1'b1;
      bus.ser_in   = 1'($urandom_range(1));
      tick();
    end
    bus.shift_en  = 1'b0;
    bus.word_sync = 1'b1;
    tick();
    bus.word_sync = 1'b0;
    send_cmd(1'b0, 5'd17, 5'd31, 2'd3, 1'b0);
    check("t2_cs_src_all_ones", bus.cs_out, 1'b0);
    tick();

    // Full transfer on channel 1 with io_ready=0010
    send_cmd(1'b0, 5'd31, 5'd5, 2'd0, 1'b0);
    run_xfer(5'd5, 0);

    // Stalled transfer: timeout after the 15th stall
    send_cmd(1'b1, 5'd31, 5'd14, 2'd1, 1'b1);
    run_xfer(5'd14, 1);
    repeat (3) tick();
    check("timeout_sticky", bus.io_timeout, 1'b1);

    // Exec and a new commit while busy leave the running transfer untouched
    send_cmd(1'b0, 5'd31, 5'd6, 2'd0, 1'b0);
    exp_io.push_back(mk_ev(K_START, 4'b0100, 1'b0));
    repeat (XFER_BITS) exp_io.push_back(mk_ev(K_SHIFT, 4'b0100, 1'b0));
    exp_io.push_back(mk_ev(K_STOP, 4'b0100, 1'b0));
    exp_busy.push_back(XFER_BITS + 2);
    bus.exec = 1'b1;
    tick();
    bus.exec     = 1'b0;
    bus.io_ready = 4'b1111;
    repeat (3) tick();
    send_cmd(1'b1, 5'd31, 5'd1, 2'd3, 1'b0);
    check("t6_new_dest_onehot", bus.dest_onehot, 64'h8000_0000);
    check("t6_new_src_onehot", bus.src_onehot, 64'h2);
    bus.exec = 1'b1;
    tick();
    bus.exec = 1'b0;
    repeat (15) tick();
    bus.io_ready = '0;
    tick();
    check("t6_idle_after", bus.io_busy, 1'b0);

    // Reset in the middle of XFER: no stop pulse, everything back to idle
    send_cmd(1'b0, 5'd31, 5'd3, 2'd1, 1'b0);
    exp_io.push_back(mk_ev(K_START, 4'b1000, 1'b0));
    repeat (5) exp_io.push_back(mk_ev(K_SHIFT, 4'b1000, 1'b0));
    exp_busy.push_back(6);
    bus.exec = 1'b1;
    tick();
    bus.exec     = 1'b0;
    bus.io_ready = 4'b1000;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst          = 1'b1;
    bus.io_ready = '0;
    check("t7_busy", bus.io_busy, 1'b0);
    check("t7_io", {bus.io_start, bus.io_stop, bus.io_shift}, 64'd0);
    check("t7_dest_onehot", bus.dest_onehot, 64'd1);
    check("t7_timeout", bus.io_timeout, 1'b0);
    repeat (3) tick();

    // Randomized commands and transfers
    for (int it = 0; it < 12; it++) begin
      logic [D_W-1:0]  d;
      logic [S_W-1:0]  s;
      logic [CH_W-1:0] c;
      int              r;
      d = ($urandom_range(1) == 0) ? 5'd31 : 5'($urandom);
      s = 5'($urandom);
      c = 2'($urandom);
      if ($urandom_range(2) == 0) begin
        r = $urandom_range(1, W - 1);
        for (int i = 0; i < r; i++) begin
          bus.shift_en  = 1'b1;
          bus.ser_in    = 1'($urandom_range(1));
          bus.word_sync = (i == r - 1);
          tick();
        end
        bus.shift_en  = 1'b0;
        bus.word_sync = 1'b0;
      end
      send_cmd(1'($urandom), d, s, c, 1'b1);
      if (d == 5'd31) begin
        run_xfer(s, (it % 3 == 0) ? 3 : ((it % 3 == 1) ? 2 : 0));
      end else begin
        bus.exec = 1'b1;
        tick();
        bus.exec = 1'b0;
        repeat (3) tick();
      end
    end

    repeat (5) tick();
    check("leftover_cmd", 64'(exp_cmd.size()), 64'd0);
    check("leftover_io", 64'(exp_io.size()), 64'd0);
    check("leftover_busy", 64'(exp_busy.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete within the time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
